// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: character frame buffer refreshed onto an HD44780 8-bit bus.
//
// A ROWS x COLS byte buffer is written by a client one character at a time.
// Each row carries a dirty bit. After power-up and controller init, the bus
// FSM repaints dirty rows, lowest row first. Every bus transaction occupies
// one slot of 2*EN_DIV clk cycles with lcd_en high on slot cycles 1..EN_DIV.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   wr_en     character write strobe
//   wr_addr   linear character index row*COLS+col
//   wr_data   character code
//   clear     request to blank the whole buffer to spaces
//   wr_ready  writes/clear accepted when high (low only while blanking)
//   busy      high unless the FSM is idle and no blanking is running
//   lcd_rs, lcd_rw, lcd_en, lcd_dat   HD44780 8-bit bus
//
// state    | meaning
// ---------+----------------------------------------------------------
// PWRUP    | idle slots after reset while the panel powers up
// INIT     | function set, display on, entry mode, clear display
// CLRWAIT  | idle slots while the panel executes its clear command
// IDLE     | waiting for a dirty row at a slot boundary
// SETADDR  | DDRAM address command for the selected row
// DATA     | COLS character writes for the selected row

module lcd_text_ctrl #(
    parameter int COLS        = 16,
    parameter int ROWS        = 2,
    parameter int EN_DIV      = 32768,
    parameter int PWRUP_SLOTS = 16,
    parameter int CLR_SLOTS   = 2,
    localparam int AW         = $clog2(ROWS * COLS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          clear,
    output logic          wr_ready,
    output logic          busy,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic          lcd_en,
    output logic [7:0]    lcd_dat
);

    localparam int N  = ROWS * COLS;
    localparam int T  = 2 * EN_DIV;
    localparam int CW = $clog2(T);
    localparam int SW = 16;
    localparam int RW = 2;

    localparam logic [2:0] S_PWRUP   = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_CLRWAIT = 3'd2;
    localparam logic [2:0] S_IDLE    = 3'd3;
    localparam logic [2:0] S_SETADDR = 3'd4;
    localparam logic [2:0] S_DATA    = 3'd5;

    logic [7:0]      fbuf [N];
    logic [ROWS-1:0] dirty, dirty_nx;
    logic [2:0]      state, nx_state;
    logic [CW-1:0]   slot_cnt;
    logic [SW-1:0]   sub_cnt, nx_sub, rd_col;
    logic [RW-1:0]   cur_row, nx_row, pick_row, wr_row;
    logic            slot_act, nx_act, nx_rs, do_pick;
    logic [7:0]      nx_dat, rd_byte;
    logic [AW-1:0]   rd_idx;
    logic            fill_act;
    logic [AW-1:0]   fill_idx;
    logic            wr_ok, slot_end, fill_done;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [7:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'(COLS);
            default: return 8'(64 + COLS);
        endcase
    endfunction

    assign slot_end  = (slot_cnt == CW'(T - 1));
    assign fill_done = fill_act && (fill_idx == AW'(N - 1));
    assign wr_ready  = !fill_act;
    assign busy      = !((state == S_IDLE) && !fill_act);
    assign lcd_rw    = 1'b0;

    // A write in the same cycle as an accepted clear is dropped.
    always_comb begin
        wr_ok  = wr_en && !fill_act && !clear && (int'(wr_addr) < N);
        wr_row = '0;
        for (int r = 1; r < ROWS; r++)
            if (int'(wr_addr) >= r * COLS) wr_row = RW'(r);
    end

    // Next-slot decision, applied only at the last cycle of each slot.
    always_comb begin
        pick_row = '0;
        for (int r = ROWS - 1; r >= 0; r--)
            if (dirty[r]) pick_row = RW'(r);
        rd_col   = (state == S_SETADDR) ? '0 : sub_cnt + SW'(1);
        rd_idx   = AW'(int'(cur_row) * COLS + int'(rd_col));
        rd_byte  = fbuf[rd_idx];
        nx_state = state;
        nx_sub   = sub_cnt;
        nx_row   = cur_row;
        nx_act   = 1'b0;
        nx_rs    = lcd_rs;
        nx_dat   = lcd_dat;
        do_pick  = 1'b0;
        case (state)
            S_PWRUP: begin
                if (sub_cnt == SW'(PWRUP_SLOTS - 1)) begin
                    nx_state = S_INIT;
                    nx_sub   = '0;
                    nx_act   = 1'b1;
                    nx_rs    = 1'b0;
                    nx_dat   = init_cmd(2'd0);
                end else begin
                    nx_sub = sub_cnt + SW'(1);
                end
            end
            S_INIT: begin
                if (sub_cnt == SW'(3)) begin
                    if (CLR_SLOTS == 0) begin
                        do_pick = 1'b1;
                    end else begin
                        nx_state = S_CLRWAIT;
                        nx_sub   = '0;
                    end
                end else begin
                    nx_sub = sub_cnt + SW'(1);
                    nx_act = 1'b1;
                    nx_rs  = 1'b0;
                    nx_dat = init_cmd(sub_cnt[1:0] + 2'd1);
                end
            end
            S_CLRWAIT: begin
                if (sub_cnt == SW'(CLR_SLOTS - 1)) do_pick = 1'b1;
                else nx_sub = sub_cnt + SW'(1);
            end
            S_SETADDR: begin
                nx_state = S_DATA;
                nx_sub   = '0;
                nx_act   = 1'b1;
                nx_rs    = 1'b1;
                nx_dat   = rd_byte;
            end
            S_DATA: begin
                if (sub_cnt == SW'(COLS - 1)) begin
                    do_pick = 1'b1;
                end else begin
                    nx_sub = sub_cnt + SW'(1);
                    nx_act = 1'b1;
                    nx_rs  = 1'b1;
                    nx_dat = rd_byte;
                end
            end
            default: do_pick = 1'b1;
        endcase
        // Leaving CLRWAIT or DATA re-evaluates the dirty rows at the same
        // boundary, so back-to-back rows have no idle slot between them.
        if (do_pick) begin
            nx_sub = '0;
            if (|dirty) begin
                nx_state = S_SETADDR;
                nx_row   = pick_row;
                nx_act   = 1'b1;
                nx_rs    = 1'b0;
                nx_dat   = 8'h80 | row_base(pick_row);
            end else begin
                nx_state = S_IDLE;
            end
        end
    end

    // Client write wins over the refresh clearing the same row's bit, so a
    // row touched during its own refresh is sent again.
    always_comb begin
        dirty_nx = dirty;
        if (slot_end && do_pick)
            for (int r = 0; r < ROWS; r++)
                if (RW'(r) == pick_row) dirty_nx[r] = 1'b0;
        if (fill_done) dirty_nx = '1;
        if (wr_ok)
            for (int r = 0; r < ROWS; r++)
                if (wr_row == RW'(r)) dirty_nx[r] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_PWRUP;
            slot_cnt <= '0;
            sub_cnt  <= '0;
            cur_row  <= '0;
            slot_act <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_dat  <= 8'h00;
            dirty    <= '0;
            fill_act <= 1'b1;
            fill_idx <= '0;
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + CW'(1);
            lcd_en   <= !slot_end && slot_act && (int'(slot_cnt) + 1 <= EN_DIV);
            if (slot_end) begin
                state    <= nx_state;
                sub_cnt  <= nx_sub;
                cur_row  <= nx_row;
                slot_act <= nx_act;
                lcd_rs   <= nx_rs;
                lcd_dat  <= nx_dat;
            end
            if (fill_act) begin
                fill_idx <= fill_done ? '0 : fill_idx + AW'(1);
                fill_act <= !fill_done;
            end else if (clear) begin
                fill_act <= 1'b1;
                fill_idx <= '0;
            end
            dirty <= dirty_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_act) fbuf[fill_idx] <= 8'h20;
        else if (wr_ok) fbuf[wr_addr] <= wr_data;
    end

endmodule
